// File: rtl/wb_host_bridge_pkg.sv
// Shared types and constants for the GN4124-to-Wishbone host bridge.
package wb_host_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } t_bridge_state;

  localparam logic [1:0]  c_ST_OK      = 2'b00;
  localparam logic [1:0]  c_ST_ERR     = 2'b01;
  localparam logic [1:0]  c_ST_TIMEOUT = 2'b10;
  localparam logic [1:0]  c_ST_MISS    = 2'b11;

  localparam logic [31:0] c_FAIL_DATA  = 32'hFFFF_FFFF;

endpackage

// File: rtl/wb_host_bridge_timeout.sv
// Bus-cycle watchdog: loads g_timeout_cycles-1 on clear, counts down while enabled,
// and flags expiry when the count reaches zero.
module wb_host_bridge_timeout #(
  parameter int unsigned g_timeout_cycles = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned     c_W    = $clog2(g_timeout_cycles);
  localparam logic [c_W-1:0]  c_LOAD = c_W'(g_timeout_cycles - 1);

  logic [c_W-1:0] r_cnt;

  // Down-counting from the limit is equivalent to an up-counter compared against
  // g_timeout_cycles-1: expiry is seen on the g_timeout_cycles-th enabled edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= c_LOAD;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - c_W'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/wb_host_bridge.sv
// Single-outstanding bridge from host register requests to Wishbone pipelined
// cycles on the WRPC window, with decode, stall, error and timeout handling.
module wb_host_bridge
  import wb_host_bridge_pkg::*;
#(
  parameter logic [31:0] g_base_addr      = 32'h0008_0000,
  parameter int unsigned g_window_bits    = 17,
  parameter int unsigned g_timeout_cycles = 1024
) (
  input  logic                     clk_sys_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [31:0]              req_addr_i,
  input  logic [31:0]              req_data_i,
  input  logic [3:0]               req_sel_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [31:0]              rsp_data_o,
  output logic [1:0]               rsp_status_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic                     wb_we_o,
  output logic [g_window_bits-3:0] wb_adr_o,
  output logic [3:0]               wb_sel_o,
  output logic [31:0]              wb_dat_o,
  input  logic [31:0]              wb_dat_i,
  input  logic                     wb_ack_i,
  input  logic                     wb_err_i,
  input  logic                     wb_stall_i
);

  t_bridge_state             r_state;
  logic                      r_req_ready;
  logic                      r_rsp_valid;
  logic [31:0]               r_rsp_data;
  logic [1:0]                r_rsp_status;
  logic                      r_cyc;
  logic                      r_stb;
  logic                      r_we;
  logic [g_window_bits-3:0]  r_adr;
  logic [3:0]                r_sel;
  logic [31:0]               r_dat;

  logic w_hit;
  logic w_accept;
  logic w_busy;
  logic w_expired;
  logic w_unused;

  assign w_hit    = (req_addr_i[31:g_window_bits] == g_base_addr[31:g_window_bits]);
  assign w_accept = req_valid_i & r_req_ready;
  assign w_busy   = (r_state == ISSUE) || (r_state == WAIT);
  assign w_unused = ^req_addr_i[1:0];

  wb_host_bridge_timeout #(
    .g_timeout_cycles(g_timeout_cycles)
  ) u_timeout (
    .i_clk     (clk_sys_i),
    .i_rst     (rst_i),
    .i_clr     (w_accept),
    .i_en      (w_busy),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_status <= c_ST_OK;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_sel        <= '0;
      r_dat        <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            if (w_hit) begin
              r_state <= ISSUE;
              r_cyc   <= 1'b1;
              r_stb   <= 1'b1;
              r_we    <= req_we_i;
              r_adr   <= req_addr_i[g_window_bits-1:2];
              r_sel   <= req_sel_i;
              r_dat   <= req_data_i;
            end else begin
              r_state      <= RESP;
              r_rsp_valid  <= 1'b1;
              r_rsp_status <= c_ST_MISS;
              r_rsp_data   <= c_FAIL_DATA;
            end
          end
        end

        // A slave response always beats the watchdog, and err beats ack.
        ISSUE, WAIT: begin
          if (wb_ack_i || wb_err_i) begin
            r_state     <= RESP;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_valid <= 1'b1;
            if (wb_err_i) begin
              r_rsp_status <= c_ST_ERR;
              r_rsp_data   <= c_FAIL_DATA;
            end else begin
              r_rsp_status <= c_ST_OK;
              r_rsp_data   <= r_we ? '0 : wb_dat_i;
            end
          end else if (w_expired) begin
            r_state      <= RESP;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_rsp_status <= c_ST_TIMEOUT;
            r_rsp_data   <= c_FAIL_DATA;
          end else if ((r_state == ISSUE) && !wb_stall_i) begin
            r_state <= WAIT;
            r_stb   <= 1'b0;
          end
        end

        RESP: begin
          if (rsp_ready_i) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = r_req_ready;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_data_o   = r_rsp_data;
  assign rsp_status_o = r_rsp_status;
  assign wb_cyc_o     = r_cyc;
  assign wb_stb_o     = r_stb;
  assign wb_we_o      = r_we;
  assign wb_adr_o     = r_adr;
  assign wb_sel_o     = r_sel;
  assign wb_dat_o     = r_dat;

endmodule

// File: tb/tb_wb_host_bridge.sv
// Self-checking bench for wb_host_bridge: vector table with a behavioural Wishbone
// slave and a response scoreboard, plus hand sequences for timeout, backpressure and reset.
module tb_wb_host_bridge;
  import wb_host_bridge_pkg::*;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        wb_cyc, wb_stb, wb_we;
  logic [14:0] wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic        wb_ack, wb_err, wb_stall;

  always #5 clk = ~clk;

  wb_host_bridge #(
    .g_base_addr      (32'h0008_0000),
    .g_window_bits    (17),
    .g_timeout_cycles (TO)
  ) dut (
    .clk_sys_i    (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .req_sel_i    (req_sel),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .rsp_status_o (rsp_status),
    .wb_cyc_o     (wb_cyc),
    .wb_stb_o     (wb_stb),
    .wb_we_o      (wb_we),
    .wb_adr_o     (wb_adr),
    .wb_sel_o     (wb_sel),
    .wb_dat_o     (wb_dat_o),
    .wb_dat_i     (wb_dat_i),
    .wb_ack_i     (wb_ack),
    .wb_err_i     (wb_err),
    .wb_stall_i   (wb_stall)
  );

  // kind: 0 = ack, 1 = err, 2 = ack and err together
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int unsigned stall;
    int unsigned dly;
    logic [1:0]  kind;
    logic [31:0] rdata;
    logic        miss;
    logic [14:0] adr;
    logic [1:0]  st;
    logic [31:0] rsp;
  } vec_t;

  typedef struct packed {
    logic [1:0]  st;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  vec_t        vecs[9];
  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pop_check(input string nm);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_sb: got empty scoreboard expected an entry", nm);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_status"}, 32'(rsp_status), 32'(e.st));
      chk({nm, "_data"}, rsp_data, e.data);
    end
  endtask

  task automatic start_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] sel, output bit ok);
    int unsigned n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("start_ready", 32'(req_ready), 32'd1);
    ok = req_ready;
    if (!ok) return;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_data  = data;
    req_sel   = sel;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic handshake(input string nm);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({nm, "_hs_valid"}, 32'(rsp_valid), 32'd0);
    chk({nm, "_hs_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    bit          ok, got, saw_cyc, rdy_busy;
    int unsigned stall_left, stb_cnt, lat;
    int          dly;
    exp_t        e;
    start_req(v.we, v.addr, v.wdata, v.sel, ok);
    if (!ok) return;
    e.st   = v.st;
    e.data = v.rsp;
    exp_q.push_back(e);
    stall_left = v.stall;
    dly        = -1;
    stb_cnt    = 0;
    lat        = 0;
    got        = 0;
    saw_cyc    = 0;
    rdy_busy   = 0;
    for (int unsigned n = 1; n <= 60; n++) begin
      wb_ack   = 1'b0;
      wb_err   = 1'b0;
      wb_stall = 1'b0;
      wb_dat_i = 32'h0BAD_0BAD;
      if (rsp_valid) begin
        lat = n;
        got = 1;
        break;
      end
      if (wb_cyc) saw_cyc = 1;
      if (req_ready) rdy_busy = 1;
      if (wb_cyc && wb_stb) begin
        stb_cnt++;
        if (stall_left > 0) begin
          wb_stall = 1'b1;
          stall_left--;
        end else begin
          chk({nm, "_adr"}, 32'(wb_adr), 32'(v.adr));
          chk({nm, "_we"}, 32'(wb_we), 32'(v.we));
          chk({nm, "_sel"}, 32'(wb_sel), 32'(v.sel));
          if (v.we) chk({nm, "_wdat"}, wb_dat_o, v.wdata);
          dly = int'(v.dly);
        end
      end
      if (wb_cyc && dly == 0) begin
        wb_ack   = (v.kind != 2'd1);
        wb_err   = (v.kind != 2'd0);
        wb_dat_i = v.rdata;
        dly      = -1;
      end else if (dly > 0) begin
        dly--;
      end
      @(posedge clk); #1;
    end
    wb_ack   = 1'b0;
    wb_err   = 1'b0;
    wb_stall = 1'b0;
    chk({nm, "_rsp_seen"}, 32'(got), 32'd1);
    if (!got) return;
    chk({nm, "_latency"}, lat, v.miss ? 32'd1 : 32'(2 + v.stall + v.dly));
    chk({nm, "_stb_cycles"}, stb_cnt, v.miss ? 32'd0 : 32'(v.stall + 1));
    chk({nm, "_cyc_seen"}, 32'(saw_cyc), 32'(!v.miss));
    chk({nm, "_ready_busy"}, 32'(rdy_busy), 32'd0);
    pop_check(nm);
    handshake(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int unsigned cyc_cnt;
    exp_t        e;

    // fields: we, addr, wdata, sel, stall, dly, kind, rdata, miss, adr, status, rsp data
    vecs[0] = '{1'b0, 32'h0008_0100, 32'h0000_0000, 4'hF, 0, 0, 2'd0, 32'hDEAD_BEEF, 1'b0, 15'h0040, c_ST_OK,   32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h0008_0104, 32'hCAFE_BABE, 4'hF, 3, 0, 2'd0, 32'h0BAD_F00D, 1'b0, 15'h0041, c_ST_OK,   32'h0000_0000};
    vecs[2] = '{1'b0, 32'h000A_0400, 32'h0000_0000, 4'hF, 0, 0, 2'd0, 32'h0000_0000, 1'b1, 15'h0000, c_ST_MISS, 32'hFFFF_FFFF};
    vecs[3] = '{1'b0, 32'h0008_0200, 32'h0000_0000, 4'hF, 1, 2, 2'd1, 32'h1111_2222, 1'b0, 15'h0080, c_ST_ERR,  32'hFFFF_FFFF};
    vecs[4] = '{1'b0, 32'h0008_0000, 32'h0000_0000, 4'hF, 0, 0, 2'd2, 32'h3333_4444, 1'b0, 15'h0000, c_ST_ERR,  32'hFFFF_FFFF};
    vecs[5] = '{1'b1, 32'h0009_FFFC, 32'hA5A5_5A5A, 4'h3, 0, 1, 2'd0, 32'h7777_8888, 1'b0, 15'h7FFF, c_ST_OK,   32'h0000_0000};
    vecs[6] = '{1'b0, 32'h0007_FFFC, 32'h0000_0000, 4'hF, 0, 0, 2'd0, 32'h0000_0000, 1'b1, 15'h0000, c_ST_MISS, 32'hFFFF_FFFF};
    vecs[7] = '{1'b0, 32'h0008_0003, 32'h0000_0000, 4'h1, 2, 0, 2'd0, 32'h1234_5678, 1'b0, 15'h0000, c_ST_OK,   32'h1234_5678};
    vecs[8] = '{1'b1, 32'hFFF8_0000, 32'h0000_0001, 4'hF, 0, 0, 2'd0, 32'h0000_0000, 1'b1, 15'h0000, c_ST_MISS, 32'hFFFF_FFFF};

    rst       = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0008_0100;
    req_data  = '0;
    req_sel   = 4'hF;
    rsp_ready = 1'b0;
    wb_dat_i  = '0;
    wb_ack    = 1'b0;
    wb_err    = 1'b0;
    wb_stall  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst       = 1'b0;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_status", 32'(rsp_status), 32'd0);
    chk("reset_cyc", 32'(wb_cyc), 32'd0);
    chk("reset_stb", 32'(wb_stb), 32'd0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Slave never answers: watchdog aborts, then a late ack must not disturb the response.
    start_req(1'b0, 32'h0008_0000, 32'h0, 4'hF, ok);
    if (ok) begin
      e.st   = c_ST_TIMEOUT;
      e.data = c_FAIL_DATA;
      exp_q.push_back(e);
      cyc_cnt = 0;
      for (int unsigned n = 0; n < 40 && wb_cyc; n++) begin
        cyc_cnt++;
        @(posedge clk); #1;
      end
      chk("to_cyc_cycles", cyc_cnt, TO);
      chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
      pop_check("to");
      @(posedge clk); #1;
      wb_ack   = 1'b1;
      wb_dat_i = 32'h5555_AAAA;
      @(posedge clk); #1;
      wb_ack   = 1'b0;
      chk("to_late_status", 32'(rsp_status), 32'(c_ST_TIMEOUT));
      chk("to_late_data", rsp_data, c_FAIL_DATA);
      chk("to_late_valid", 32'(rsp_valid), 32'd1);
      chk("to_late_cyc", 32'(wb_cyc), 32'd0);
      handshake("to");
    end

    // ack+err together, then response held for five cycles of backpressure.
    start_req(1'b0, 32'h0008_0008, 32'h0, 4'hF, ok);
    if (ok) begin
      e.st   = c_ST_ERR;
      e.data = c_FAIL_DATA;
      exp_q.push_back(e);
      chk("bp_stb", 32'(wb_stb), 32'd1);
      chk("bp_ready_busy", 32'(req_ready), 32'd0);
      wb_ack   = 1'b1;
      wb_err   = 1'b1;
      wb_dat_i = 32'h9999_9999;
      @(posedge clk); #1;
      wb_ack   = 1'b0;
      wb_err   = 1'b0;
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      pop_check("bp");
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        chk($sformatf("bp_hold%0d_valid", k), 32'(rsp_valid), 32'd1);
        chk($sformatf("bp_hold%0d_status", k), 32'(rsp_status), 32'(c_ST_ERR));
        chk($sformatf("bp_hold%0d_data", k), rsp_data, c_FAIL_DATA);
        chk($sformatf("bp_hold%0d_ready", k), 32'(req_ready), 32'd0);
      end
      handshake("bp");
    end

    // Reset while waiting for the slave aborts the bus cycle cleanly.
    start_req(1'b1, 32'h0008_0010, 32'h7E57_7E57, 4'hC, ok);
    if (ok) begin
      @(posedge clk); #1;
      chk("rw_pre_cyc", 32'(wb_cyc), 32'd1);
      chk("rw_pre_stb", 32'(wb_stb), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rw_cyc", 32'(wb_cyc), 32'd0);
      chk("rw_stb", 32'(wb_stb), 32'd0);
      chk("rw_we", 32'(wb_we), 32'd0);
      chk("rw_adr", 32'(wb_adr), 32'd0);
      chk("rw_sel", 32'(wb_sel), 32'd0);
      chk("rw_dat", wb_dat_o, 32'd0);
      chk("rw_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rw_req_ready", 32'(req_ready), 32'd1);
      run_vec(vecs[0], "rw_after");
    end

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_host_bridge.md
Name: wb_host_bridge

Overview:
- Converts single-word register requests from the GN4124 host interface core into Wishbone pipelined cycles towards the WRPC crossbar window.
- Sits directly downstream of the host (PCIe) core and directly upstream of the WRPC slave window at base 0x0080000.
- Performs window decode, stall handling, error reporting and timeout.
- Keeps at most one outstanding transaction.

Parameters:
- g_base_addr, 32'h0008_0000, byte base address of the WRPC window.
- g_window_bits, 17, log2 of the window size in bytes (128 KiB).
- g_timeout_cycles, 1024, clk_sys_i cycles from first stb to forced abort; must be at least 2.

Ports:
- clk_sys_i  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  bridge can accept a request.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  32  byte address, absolute host address.
- req_data_i  in  32  write data.
- req_sel_i  in  4  byte enables.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_data_o  out  32  read data (0 for writes, 32'hFFFF_FFFF on failure).
- rsp_status_o  out  2  00 OK, 01 bus error, 10 timeout, 11 decode miss.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  Wishbone write enable.
- wb_adr_o  out  g_window_bits-2  word address, relative to g_base_addr.
- wb_sel_o  out  4  Wishbone byte select.
- wb_dat_o  out  32  Wishbone write data.
- wb_dat_i  in  32  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_err_i  in  1  Wishbone error.
- wb_stall_i  in  1  Wishbone stall.

Behaviour:
- Reset state (rst_i high at an edge): state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_status_o=00, all wb_* outputs 0, timeout counter 0. Reset wins over every other event, including mid-cycle. Dropping wb_cyc_o on reset is the required abort.
- All outputs are registered. req_ready_o=1 only in IDLE.
- Decode: hit when req_addr_i[31:g_window_bits] == g_base_addr[31:g_window_bits]. wb_adr_o = req_addr_i[g_window_bits-1:2]. Low 2 address bits are ignored.
- FSM IDLE:
  - On accept (req_valid_i & req_ready_o) with a miss: go to RESP with status 11, data FFFF_FFFF. No bus activity.
  - On accept with a hit: latch we/adr/sel/dat, drive cyc=stb=1 from the next cycle, go to ISSUE, clear the counter.
- FSM ISSUE:
  - stb held while wb_stall_i=1.
  - On a cycle with stall=0: stb drops next cycle and the state goes to WAIT.
  - If ack or err arrives in that same non-stalled cycle, complete directly (skip WAIT).
- FSM WAIT:
  - cyc held, stb=0.
  - On wb_ack_i: capture wb_dat_i (reads only; writes return 0), status 00.
  - On wb_err_i: status 01, data FFFF_FFFF.
  - ack and err in the same cycle: err wins.
  - On completion: cyc=0 next cycle, go to RESP.
- Timeout:
  - Counter increments every cycle in ISSUE and WAIT.
  - When it reaches g_timeout_cycles-1 with no ack/err: cyc=stb=0 next cycle, status 10, data FFFF_FFFF, go to RESP.
  - An ack/err in the terminal cycle takes priority over the timeout.
  - A late ack/err after cyc drops is ignored.
- FSM RESP:
  - rsp_valid_o=1; data and status stay stable until rsp_ready_i.
  - On the handshake: rsp_valid_o=0 next cycle, go to IDLE (req_ready_o=1 in that same cycle).
- Minimum latency:
  - Accept at edge k; cyc/stb high during cycle k+1.
  - Zero-wait slave acks in k+1; rsp_valid_o high at k+2. Next accept possible at k+3 if rsp_ready_i=1.
- ack/err outside cyc: ignored.

Decomposition:
- Package wb_host_bridge_pkg:
  - t_bridge_state enum {IDLE, ISSUE, WAIT, RESP}.
  - Status constants c_ST_OK, c_ST_ERR, c_ST_TIMEOUT, c_ST_MISS.
  - c_FAIL_DATA = 32'hFFFF_FFFF.
- Sub-module wb_host_bridge_timeout: loadable down-counter with clear and enable, exposing an expired flag. Its counting must implement the g_timeout_cycles-1 limit above.
- Everything else lives in a single FSM module.

Test Plan:
- Read 0x0080100, slave acks same cycle with 0xDEADBEEF, no stall -> one stb cycle, wb_adr_o=0x40, rsp_valid at k+2, data 0xDEADBEEF, status 00.
- Write 0x0080104 data 0xCAFEBABE sel 4'hF, stall for 3 cycles -> stb high 4 cycles, wb_dat_o=0xCAFEBABE, wb_we_o=1, rsp status 00, data 0.
- Read 0x00A0400 (outside window) -> no cyc ever asserted, rsp status 11, data FFFF_FFFF at k+1.
- Read 0x0080000, slave never acks, g_timeout_cycles=16 -> cyc drops after 16 cycles, status 10. A late ack 2 cycles later does not change state.
- Read with ack and err both in one cycle -> status 01, data FFFF_FFFF. rsp_ready_i held low 5 cycles -> rsp fields stable, req_ready_o low throughout.
- rst_i pulsed while in WAIT -> next cycle all wb_* 0, rsp_valid_o 0, req_ready_o 1. A following read completes normally.
